pe_flex: RTL

PE_FLEX -- requirements
Module: pe_flex

---
 rtl/pe_pkg.sv | 37 +++
 rtl/pe_requant.sv | 25 ++
 rtl/pe_flex.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/pe_pkg.sv
// rtl/pe_pkg.sv - shared mode encodings and signed saturation helpers for the PE family
package pe_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE       = 2'b00,
        MODE_WS_LOAD    = 2'b01,
        MODE_OS         = 2'b10,
        MODE_WS_COMPUTE = 2'b11
    } pe_mode_e;

    // Arithmetic is widened to this width before clipping, so callers need width < WIDE_W.
    localparam int WIDE_W = 64;
    typedef logic signed [WIDE_W-1:0] wide_t;

    function automatic wide_t sat_max(input int w);
        return (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    endfunction

    function automatic wide_t sat_min(input int w);
        return -(wide_t'(1) <<< (w - 1));
    endfunction

    function automatic logic sat_hit(input wide_t x, input int w);
        return (x > sat_max(w)) || (x < sat_min(w));
    endfunction

    function automatic wide_t sat_clip(input wide_t x, input int w);
        if (x > sat_max(w)) begin
            return sat_max(w);
        end
        if (x < sat_min(w)) begin
            return sat_min(w);
        end
        return x;
    endfunction

endpackage

// File: rtl/pe_requant.sv
// rtl/pe_requant.sv - combinational round-half-up, arithmetic right shift, saturate to OUT_W
module pe_requant
    import pe_pkg::*;
#(
    parameter int IN_W  = 20,
    parameter int OUT_W = 8,
    parameter int SHIFT = 4
) (
    input  logic [IN_W-1:0]  din,
    output logic [OUT_W-1:0] dout
);

    localparam wide_t ROUND = (SHIFT == 0) ? wide_t'(0)
                                           : (wide_t'(1) <<< ((SHIFT > 0) ? SHIFT - 1 : 0));

    wide_t din_ext;
    wide_t shifted;

    always_comb begin
        din_ext = wide_t'($signed(din));
        shifted = (din_ext + ROUND) >>> SHIFT;
        dout    = OUT_W'(sat_clip(shifted, OUT_W));
    end

endmodule

// File: rtl/pe_flex.sv
// rtl/pe_flex.sv - flexible systolic PE: weight-stationary / output-stationary MAC with drain chain
module pe_flex
    import pe_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20,
    parameter int OUT_W  = 8,
    parameter int SHIFT  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mode,
    input  logic              w_swap,
    input  logic              acc_clr,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_vld_in,
    input  logic [ACC_W-1:0]  ws_in,
    input  logic              ws_vld_in,
    input  logic              drain_load,
    input  logic              drain_shift,
    input  logic [OUT_W-1:0]  drain_in,
    input  logic              drain_vld_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_vld_out,
    output logic [ACC_W-1:0]  ws_out,
    output logic              ws_vld_out,
    output logic [OUT_W-1:0]  drain_out,
    output logic              drain_vld_out,
    output logic [ACC_W-1:0]  acc_out,
    output logic              sat_flag
);

    pe_mode_e          mode_e, mode_q, mode_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              data_vld_q, data_vld_d;
    logic [ACC_W-1:0]  ws_q, ws_d;
    logic              ws_vld_q, ws_vld_d;
    logic [OUT_W-1:0]  drain_q, drain_d;
    logic              drain_vld_q, drain_vld_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic              sat_q, sat_d;
    logic [DATA_W-1:0] w_shadow_q, w_shadow_d;
    logic [DATA_W-1:0] w_active_q, w_active_d;
    logic              shadow_full_q, shadow_full_d;

    logic                       mode_stable;
    logic                       mac_fire;
    logic [DATA_W-1:0]          mult_b;
    logic signed [2*DATA_W-1:0] prod;
    wide_t                      addend;
    wide_t                      sum;
    logic [ACC_W-1:0]           sum_sat;
    logic                       sum_ovf;
    logic [OUT_W-1:0]           requant_val;

    pe_requant #(
        .IN_W  (ACC_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT)
    ) u_requant (
        .din  (acc_q),
        .dout (requant_val)
    );

    // One multiplier/adder is shared: OS multiplies by the streamed weight and adds to acc,
    // WS_COMPUTE multiplies by the active weight and adds to the incoming partial sum.
    always_comb begin
        mode_e      = pe_mode_e'(mode);
        mode_stable = (mode_e == mode_q);
        mac_fire    = data_vld_in && ws_vld_in;
        mult_b      = (mode_e == MODE_OS) ? ws_in[DATA_W-1:0] : w_active_q;
        prod        = $signed(data_in) * $signed(mult_b);
        if (mode_e == MODE_OS) begin
            addend = acc_clr ? wide_t'(0) : wide_t'($signed(acc_q));
        end else begin
            addend = wide_t'($signed(ws_in));
        end
        sum     = addend + wide_t'(prod);
        sum_sat = ACC_W'(sat_clip(sum, ACC_W));
        sum_ovf = sat_hit(sum, ACC_W);
    end

    always_comb begin
        mode_d        = mode_e;
        data_d        = data_q;
        data_vld_d    = 1'b0;
        ws_d          = ws_q;
        ws_vld_d      = 1'b0;
        drain_d       = drain_q;
        drain_vld_d   = drain_vld_q;
        acc_d         = acc_q;
        sat_d         = sat_q;
        w_shadow_d    = w_shadow_q;
        w_active_d    = w_active_q;
        shadow_full_d = shadow_full_q;

        if (w_swap) begin
            w_active_d = w_shadow_q;
        end
        if (acc_clr) begin
            acc_d = '0;
            sat_d = 1'b0;
        end

        // The cycle in which mode differs from mode_q is a bubble for the datapath.
        if (mode_stable) begin
            case (mode_e)
                MODE_WS_LOAD: begin
                    if (ws_vld_in) begin
                        w_shadow_d    = ws_in[DATA_W-1:0];
                        shadow_full_d = 1'b1;
                        ws_d          = ACC_W'($signed(w_shadow_q));
                        ws_vld_d      = shadow_full_q;
                    end
                end
                MODE_WS_COMPUTE: begin
                    data_d     = data_in;
                    data_vld_d = data_vld_in;
                    if (mac_fire) begin
                        ws_d     = sum_sat;
                        ws_vld_d = 1'b1;
                        sat_d    = sat_d | sum_ovf;
                    end
                end
                MODE_OS: begin
                    data_d     = data_in;
                    data_vld_d = data_vld_in;
                    ws_d       = ws_in;
                    ws_vld_d   = ws_vld_in;
                    if (mac_fire) begin
                        acc_d = sum_sat;
                        sat_d = sat_d | sum_ovf;
                    end
                end
                default: begin
                end
            endcase
        end

        if (drain_load) begin
            drain_d     = requant_val;
            drain_vld_d = 1'b1;
        end else if (drain_shift) begin
            drain_d     = drain_in;
            drain_vld_d = drain_vld_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q        <= MODE_IDLE;
            data_q        <= '0;
            data_vld_q    <= 1'b0;
            ws_q          <= '0;
            ws_vld_q      <= 1'b0;
            drain_q       <= '0;
            drain_vld_q   <= 1'b0;
            acc_q         <= '0;
            sat_q         <= 1'b0;
            w_shadow_q    <= '0;
            w_active_q    <= '0;
            shadow_full_q <= 1'b0;
        end else begin
            mode_q        <= mode_d;
            data_q        <= data_d;
            data_vld_q    <= data_vld_d;
            ws_q          <= ws_d;
            ws_vld_q      <= ws_vld_d;
            drain_q       <= drain_d;
            drain_vld_q   <= drain_vld_d;
            acc_q         <= acc_d;
            sat_q         <= sat_d;
            w_shadow_q    <= w_shadow_d;
            w_active_q    <= w_active_d;
            shadow_full_q <= shadow_full_d;
        end
    end

    assign data_out      = data_q;
    assign data_vld_out  = data_vld_q;
    assign ws_out        = ws_q;
    assign ws_vld_out    = ws_vld_q;
    assign drain_out     = drain_q;
    assign drain_vld_out = drain_vld_q;
    assign acc_out       = acc_q;
    assign sat_flag      = sat_q;

endmodule
